vpp_stats_mc: RTL

Multi-channel, parametrised successor to the single-channel peak-to-peak meter. It accepts a time-multiplexed sample stream tagged with a channel index. Per channel, it computes max, min, peak-to-peak and mean over a fixed power-of-two window. It sits between the ADC capture/channel mux and the measurement display/UART reporting logic, and emits one tagged result per completed window.

---
 rtl/vpp_stats_pkg.sv | 27 ++
 rtl/vpp_ch_acc.sv | 71 +++++++
 rtl/vpp_stats_mc.sv | 100 ++++++++++
 3 files changed

// File: rtl/vpp_stats_pkg.sv
// Shared helpers for the multi-channel peak-to-peak / mean meter.
// Covers type extremes, channel-index width and accumulator width.
package vpp_stats_pkg;

   localparam int unsigned DEF_DATA_W   = 12;
   localparam int unsigned DEF_WIN_LOG2 = 11;
   localparam int unsigned DEF_NUM_CH   = 4;

   // Channel index width, never below one bit.
   function automatic int unsigned ch_w(input int unsigned num_ch);
      return (num_ch <= 1) ? 1 : $clog2(num_ch);
   endfunction

   function automatic int unsigned sum_w(input int unsigned data_w, input int unsigned win_log2);
      return data_w + win_log2;
   endfunction

   // Extremes of the sample type, returned as a bit pattern in the low data_w bits.
   function automatic logic [63:0] type_min(input int unsigned data_w, input bit sgn);
      return sgn ? (64'(1) << (data_w - 1)) : 64'(0);
   endfunction

   function automatic logic [63:0] type_max(input int unsigned data_w, input bit sgn);
      return sgn ? ((64'(1) << (data_w - 1)) - 64'(1)) : ((64'(1) << data_w) - 64'(1));
   endfunction

endpackage

// File: rtl/vpp_ch_acc.sv
// Per-channel window accumulator: running max/min/sum and sample count.
// Exposes the post-sample values so the top can capture them on close.
module vpp_ch_acc
   import vpp_stats_pkg::*;
#(
   parameter int unsigned DATA_W   = DEF_DATA_W,
   parameter int unsigned WIN_LOG2 = DEF_WIN_LOG2,
   parameter int unsigned SIGNED   = 0
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             clear,
   input  logic                             strobe,
   input  logic [DATA_W-1:0]                data,
   output logic                             close_c,
   output logic [DATA_W-1:0]                nxt_max_c,
   output logic [DATA_W-1:0]                nxt_min_c,
   output logic [sum_w(DATA_W, WIN_LOG2)-1:0] nxt_sum_c
);

   localparam int unsigned SUM_W = sum_w(DATA_W, WIN_LOG2);
   localparam logic [DATA_W-1:0] MIN_V = DATA_W'(type_min(DATA_W, SIGNED != 0));
   localparam logic [DATA_W-1:0] MAX_V = DATA_W'(type_max(DATA_W, SIGNED != 0));

   logic [WIN_LOG2-1:0] count;
   logic [SUM_W-1:0]    sum;
   logic [DATA_W-1:0]   acc_max;
   logic [DATA_W-1:0]   acc_min;
   logic                gt_max;
   logic                lt_min;
   logic [SUM_W-1:0]    data_ext;

   // Signedness-aware compare and accumulator extension.
   always_comb begin
      gt_max   = 1'b0;
      lt_min   = 1'b0;
      data_ext = {{WIN_LOG2{data[DATA_W-1] & (SIGNED != 0)}}, data};
      if (SIGNED != 0) begin
         gt_max = $signed(data) > $signed(acc_max);
         lt_min = $signed(data) < $signed(acc_min);
      end else begin
         gt_max = data > acc_max;
         lt_min = data < acc_min;
      end
      nxt_max_c = gt_max ? data : acc_max;
      nxt_min_c = lt_min ? data : acc_min;
      nxt_sum_c = sum + data_ext;
      close_c   = strobe && (count == {WIN_LOG2{1'b1}});
   end

   // Closing the window returns the channel to its reset state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count   <= '0;
         sum     <= '0;
         acc_max <= MIN_V;
         acc_min <= MAX_V;
      end else if (clear || close_c) begin
         count   <= '0;
         sum     <= '0;
         acc_max <= MIN_V;
         acc_min <= MAX_V;
      end else if (strobe) begin
         count   <= count + WIN_LOG2'(1);
         sum     <= nxt_sum_c;
         acc_max <= nxt_max_c;
         acc_min <= nxt_min_c;
      end
   end

endmodule

// File: rtl/vpp_stats_mc.sv
// Multi-channel max/min/peak-to-peak/mean meter over power-of-two windows.
// Routes tagged samples to per-channel accumulators and registers one result per close.
module vpp_stats_mc
   import vpp_stats_pkg::*;
#(
   parameter int unsigned DATA_W   = DEF_DATA_W,
   parameter int unsigned WIN_LOG2 = DEF_WIN_LOG2,
   parameter int unsigned NUM_CH   = DEF_NUM_CH,
   parameter int unsigned SIGNED   = 0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      restart,
   input  logic                      in_valid,
   input  logic [ch_w(NUM_CH)-1:0]   in_ch,
   input  logic [DATA_W-1:0]         in_data,
   output logic                      res_valid,
   output logic [ch_w(NUM_CH)-1:0]   res_ch,
   output logic [DATA_W-1:0]         res_max,
   output logic [DATA_W-1:0]         res_min,
   output logic [DATA_W-1:0]         res_vpp,
   output logic [DATA_W-1:0]         res_mean
);

   localparam int unsigned CH_W  = ch_w(NUM_CH);
   localparam int unsigned SUM_W = sum_w(DATA_W, WIN_LOG2);

   logic [NUM_CH-1:0] strobe;
   logic [NUM_CH-1:0] close;
   logic [DATA_W-1:0] ch_max [NUM_CH];
   logic [DATA_W-1:0] ch_min [NUM_CH];
   logic [SUM_W-1:0]  ch_sum [NUM_CH];

   logic              any_close;
   logic [CH_W-1:0]   sel_ch;
   logic [DATA_W-1:0] sel_max;
   logic [DATA_W-1:0] sel_min;
   logic [SUM_W-1:0]  sel_sum;

   // Out-of-range channel indices match no strobe; restart blocks all strobes.
   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      assign strobe[c] = in_valid && !restart && (in_ch == CH_W'(c));

      vpp_ch_acc #(
         .DATA_W   (DATA_W),
         .WIN_LOG2 (WIN_LOG2),
         .SIGNED   (SIGNED)
      ) u_acc (
         .clk       (clk),
         .rst       (rst),
         .clear     (restart),
         .strobe    (strobe[c]),
         .data      (in_data),
         .close_c   (close[c]),
         .nxt_max_c (ch_max[c]),
         .nxt_min_c (ch_min[c]),
         .nxt_sum_c (ch_sum[c])
      );
   end

   // At most one channel closes per cycle, so a priority-free select suffices.
   always_comb begin
      any_close = 1'b0;
      sel_ch    = '0;
      sel_max   = '0;
      sel_min   = '0;
      sel_sum   = '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         if (close[c]) begin
            any_close = 1'b1;
            sel_ch    = CH_W'(c);
            sel_max   = ch_max[c];
            sel_min   = ch_min[c];
            sel_sum   = ch_sum[c];
         end
      end
   end

   // Upper DATA_W bits of the sum are the floor mean for both signednesses.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         res_valid <= 1'b0;
         res_ch    <= '0;
         res_max   <= '0;
         res_min   <= '0;
         res_vpp   <= '0;
         res_mean  <= '0;
      end else begin
         res_valid <= any_close;
         if (any_close) begin
            res_ch   <= sel_ch;
            res_max  <= sel_max;
            res_min  <= sel_min;
            res_vpp  <= sel_max - sel_min;
            res_mean <= DATA_W'(sel_sum >> WIN_LOG2);
         end
      end
   end

endmodule
